// File: rtl/booth_mac_accum_if.sv
// ---------------------------------------------------------------------------
// booth_mac_accum_if
// Product-stream and frame-result bundle for booth_mac_accum.
//   Input stream : in_valid, in_ready, in_prod[PROD_W], in_last
//   Output frame : out_valid, out_ready, out_sum[ACC_W], out_count[CNT_W],
//                  out_sat
// Modports:
//   slave  - the accumulator (sinks products, sources completed frames)
//   master - the environment (sources products, sinks completed frames)
// ---------------------------------------------------------------------------
interface booth_mac_accum_if #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 16,
   parameter int CNT_W  = 8
) ();

   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_sat;

   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_sat
   );

   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_sat
   );

endinterface

// File: rtl/booth_mac_accum.sv
// ---------------------------------------------------------------------------
// booth_mac_accum
// Accumulates a stream of signed Booth-multiplier products into a saturating
// accumulator. The beat flagged in_last closes the frame: its sum, term count
// and a sticky "clipped at least once" flag are loaded into a one-entry
// output register presented over a valid/ready handshake.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - booth_mac_accum_if.slave: product stream in, frame result out
// ---------------------------------------------------------------------------
module booth_mac_accum #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 16,
   parameter int CNT_W  = 8
) (
   input logic               clk,
   input logic               rst,
   booth_mac_accum_if.slave  bus
);

   localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   // Clamp an ACC_W+1 bit sum into ACC_W bits. Returns {ovf, value}.
   // The extra bit cannot itself overflow, so a mismatch between the two
   // top bits is exactly the out-of-range condition.
   function automatic logic [ACC_W:0] sat_fn(input logic [ACC_W:0] s);
      logic [ACC_W:0] r;
      if (s[ACC_W] != s[ACC_W-1]) begin
         if (s[ACC_W] == 1'b0) begin
            r = {1'b1, MAX_POS};
         end else begin
            r = {1'b1, MIN_NEG};
         end
      end else begin
         r = {1'b0, s[ACC_W-1:0]};
      end
      return r;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic [ACC_W-1:0]  acc_r;
   logic [CNT_W-1:0]  count_r;
   logic              sticky_r;
   logic [ACC_W-1:0]  out_sum_r;
   logic [CNT_W-1:0]  out_count_r;
   logic              out_sat_r;

   logic              out_valid_s;
   logic              in_ready_s;
   logic              accept_s;
   logic [ACC_W:0]    sum_s;
   logic [ACC_W:0]    sat_res_s;
   logic              ovf_s;
   logic [ACC_W-1:0]  sat_sum_s;
   logic [CNT_W-1:0]  count_inc_s;

   // The output register is occupied exactly while in HOLD.
   assign out_valid_s   = (state_r == ST_HOLD);
   assign in_ready_s    = ~out_valid_s | bus.out_ready;
   assign accept_s      = bus.in_valid & in_ready_s;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_sum   = out_sum_r;
   assign bus.out_count = out_count_r;
   assign bus.out_sat   = out_sat_r;

   // Datapath: sign-extended add, saturation and saturating term count.
   always_comb begin
      sum_s       = {acc_r[ACC_W-1], acc_r}
                  + {{(ACC_W+1-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};
      sat_res_s   = sat_fn(sum_s);
      ovf_s       = sat_res_s[ACC_W];
      sat_sum_s   = sat_res_s[ACC_W-1:0];
      count_inc_s = count_r;
      if (count_r == CNT_MAX) begin
         count_inc_s = count_r;
      end else begin
         count_inc_s = count_r + CNT_ONE;
      end
   end

   // Next-state logic for the output-register occupancy FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ACCUM: begin
            if (accept_s && bus.in_last) begin
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         ST_HOLD: begin
            // A closing beat taken in the same cycle the held frame drains
            // refills the register immediately (no bubble).
            if (bus.out_ready) begin
               if (accept_s && bus.in_last) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_ACCUM;
               end
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: begin
            state_nxt_s = ST_ACCUM;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Accumulator, counter, sticky flag and output frame register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r       <= {ACC_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         sticky_r    <= 1'b0;
         out_sum_r   <= {ACC_W{1'b0}};
         out_count_r <= {CNT_W{1'b0}};
         out_sat_r   <= 1'b0;
      end else if (accept_s && bus.in_last) begin
         out_sum_r   <= sat_sum_s;
         out_count_r <= count_inc_s;
         out_sat_r   <= sticky_r | ovf_s;
         acc_r       <= {ACC_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         sticky_r    <= 1'b0;
      end else if (accept_s) begin
         acc_r       <= sat_sum_s;
         count_r     <= count_inc_s;
         sticky_r    <= sticky_r | ovf_s;
      end else begin
         acc_r       <= acc_r;
         count_r     <= count_r;
         sticky_r    <= sticky_r;
      end
   end

endmodule

// File: tb/tb_booth_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_booth_mac_accum
// Self-checking bench for booth_mac_accum (PROD_W=8, ACC_W=12, CNT_W=4).
// A frame-level integer model tracks the running sum, term count, sticky
// clip flag and the held result; every cycle the DUT handshake and outputs
// are compared with it. Directed table rows and sequences cover the corner
// cases, followed by 1000 randomly shaped frames.
// ---------------------------------------------------------------------------
module tb_booth_mac_accum;

   localparam int PROD_W = 8;
   localparam int ACC_W  = 12;
   localparam int CNT_W  = 4;
   localparam int SMAX   = 2047;
   localparam int SMIN   = -2048;
   localparam int CMAX   = 15;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   bit   chk_en;

   // reference model state
   int m_acc, m_cnt, m_sum, m_cntout;
   bit m_stk, m_vld, m_sat;

   booth_mac_accum_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

   booth_mac_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      bit         v;
      logic [7:0] p;
      bit         l;
      bit         r;
      bit         ev;
      logic [11:0] es;
      logic [3:0] ec;
      bit         esat;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, compare DUT to model at the falling edge,
   // advance the model across the rising edge.
   task automatic cycle(input bit v, input logic [7:0] p, input bit l,
                        input bit r, input bit rs, output bit acc);
      int pv, s, c;
      bit rdy, ovf;
      rst           = rs;
      bus.in_valid  = v;
      bus.in_prod   = p;
      bus.in_last   = l;
      bus.out_ready = r;
      @(negedge clk);
      rdy = !m_vld || r;
      if (chk_en) begin
         chk("in_ready",  32'(bus.in_ready),  32'(rdy));
         chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
         chk("out_sum",   32'(bus.out_sum),   m_sum & 32'h0000_0FFF);
         chk("out_count", 32'(bus.out_count), 32'(m_cntout));
         chk("out_sat",   32'(bus.out_sat),   32'(m_sat));
      end
      acc = v && rdy && !rs;
      if (rs) begin
         m_acc = 0; m_cnt = 0; m_stk = 1'b0;
         m_vld = 1'b0; m_sum = 0; m_cntout = 0; m_sat = 1'b0;
      end else begin
         if (m_vld && r) m_vld = 1'b0;
         if (acc) begin
            pv  = $signed(p);
            s   = m_acc + pv;
            ovf = (s > SMAX) || (s < SMIN);
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
            c   = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
            if (l) begin
               m_sum = s; m_cntout = c; m_sat = m_stk | ovf; m_vld = 1'b1;
               m_acc = 0; m_cnt = 0; m_stk = 1'b0;
            end else begin
               m_acc = s; m_cnt = c; m_stk = m_stk | ovf;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string name, input bit ev, input logic [11:0] es,
                            input logic [3:0] ec, input bit esat);
      chk({name, "_valid"}, 32'(bus.out_valid), 32'(ev));
      chk({name, "_sum"},   32'(bus.out_sum),   32'(es));
      chk({name, "_count"}, 32'(bus.out_count), 32'(ec));
      chk({name, "_sat"},   32'(bus.out_sat),   32'(esat));
   endtask

   initial begin
      bit a;
      int len, mode, tries;
      logic [7:0] p;
      total = 0; bad = 0; chk_en = 1'b0;
      bus.in_valid = 1'b0; bus.in_prod = 8'h00; bus.in_last = 1'b0; bus.out_ready = 1'b0;

      // reset and reset-state check
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
      chk_en = 1'b1;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
      check_out("reset", 1'b0, 12'h000, 4'd0, 1'b0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

      // 3-beat frame, then held-frame replacement with back-to-back one-beat frame
      tbl[0] = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0};
      tbl[1] = '{1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 12'h000, 4'd0, 1'b0};
      tbl[2] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 12'h005, 4'd3, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 12'h005, 4'd3, 1'b0};
      tbl[4] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 12'h003, 4'd1, 1'b0};
      tbl[5] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 12'h002, 4'd1, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 12'h002, 4'd1, 1'b0};
      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].r, 1'b0, a);
         check_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ec, tbl[i].esat);
      end

      // saturation and counter saturation, then sticky cleared
      for (int i = 0; i < 17; i++) cycle(1'b1, 8'h7F, (i == 16), 1'b1, 1'b0, a);
      check_out("satframe", 1'b1, 12'h7FF, 4'd15, 1'b1);
      cycle(1'b1, 8'h80, 1'b1, 1'b1, 1'b0, a);
      check_out("negframe", 1'b1, 12'hF80, 4'd1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);

      // backpressure: held frame stable, input stalled, no beat lost
      cycle(1'b1, 8'h04, 1'b1, 1'b0, 1'b0, a);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, a);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check_out("hold", 1'b1, 12'h004, 4'd1, 1'b0);
      end
      cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, a);
      chk("release_valid", 32'(bus.out_valid), 32'd0);
      cycle(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, a);
      check_out("resume", 1'b1, 12'h002, 4'd2, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);

      // reset mid-frame
      cycle(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, a);
      cycle(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, a);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a);
      check_out("midrst", 1'b0, 12'h000, 4'd0, 1'b0);
      cycle(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, a);
      check_out("postrst", 1'b1, 12'h001, 4'd1, 1'b0);

      // random frames with valid/ready gaps
      for (int f = 0; f < 1000; f++) begin
         len  = $urandom_range(1, 40);
         mode = $urandom_range(0, 2);
         for (int b = 0; b < len; b++) begin
            case (mode)
               0:       p = 8'($urandom);
               1:       p = 8'($urandom_range(64, 127));
               default: p = 8'($urandom_range(128, 192));
            endcase
            tries = 0;
            do begin
               cycle(($urandom_range(0, 3) != 0), p, (b == len - 1),
                     ($urandom_range(0, 2) != 0), 1'b0, a);
               tries++;
            end while (!a && tries < 200);
            total++;
            if (!a) begin
               bad++;
               $display("FAIL accept_bound frame=%0d beat=%0d not accepted in 200 cycles", f, b);
            end
         end
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
